// File: rtl/coax_rx.sv
// Coax line receiver.
// Recovers bi-phase words from a raw coax line: a start run of '1' cells, a
// 1.5-cell low / 1.5-cell high code violation, then one or more
// {sync, 10 data bits, parity} words, closed by a '0' cell followed by a long
// high end sequence. Good words are presented on data with a one-cycle
// data_valid strobe; faults raise a one-cycle error strobe with a cause code.
module coax_rx #(
    parameter int CLOCKS_PER_BIT = 8   // clocks per bit cell, multiple of 4, >= 8
) (
    input  logic       clk,
    input  logic       reset,          // asynchronous, active low
    input  logic       rx,
    output logic       active,
    output logic [9:0] data,
    output logic       data_valid,
    output logic       error,
    output logic [1:0] error_code
);

    localparam int T  = CLOCKS_PER_BIT;
    localparam int CW = $clog2(3 * T + 1);

    // Timing windows measured against the cell counter, which reads k-1
    // in the k-th cycle after it was cleared.
    localparam logic [CW-1:0] CNT_3Q    = CW'(3 * T / 4);
    localparam logic [CW-1:0] CNT_5Q    = CW'(5 * T / 4);
    localparam logic [CW-1:0] CNT_7Q    = CW'(7 * T / 4);
    localparam logic [CW-1:0] CNT_9Q    = CW'(9 * T / 4);
    localparam logic [CW-1:0] CNT_5H    = CW'(5 * T / 2);
    localparam logic [CW-1:0] CNT_2T_M1 = CW'(2 * T - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(3 * T);

    localparam logic [1:0] ERR_PARITY = 2'd1;
    localparam logic [1:0] ERR_NO_MID = 2'd2;
    localparam logic [1:0] ERR_END    = 2'd3;

    typedef enum logic [3:0] {
        IDLE,
        LINE_QUIESCE,
        START_BITS,
        VIOLATION_LOW,
        VIOLATION_HIGH,
        SYNC_BIT,
        DATA_BIT,
        PARITY_BIT,
        END_SEQUENCE
    } state_t;

    // [0],[1] form the synchronizer, [2] is the previous synchronized level
    logic [2:0]    sync_reg;
    state_t        state_reg;
    logic [CW-1:0] cnt_reg;
    logic [2:0]    start_cnt_reg;
    logic [3:0]    bit_cnt_reg;
    logic [9:0]    shift_reg;
    logic          fall_seen_reg;

    logic rx_s;
    logic edge_any;
    logic edge_rise;
    logic edge_fall;
    logic in_mid;
    logic past_mid;
    logic in_long;
    logic in_1p5;
    logic parity_ok;

    assign rx_s      = sync_reg[1];
    assign edge_any  = sync_reg[1] ^ sync_reg[2];
    assign edge_rise = sync_reg[1] & ~sync_reg[2];
    assign edge_fall = ~sync_reg[1] & sync_reg[2];

    // mid-bit window [3T/4, 5T/4]; beyond 5T/4 a mid-bit edge has been missed
    assign in_mid   = (cnt_reg >= CNT_3Q) && (cnt_reg <= CNT_5Q);
    assign past_mid = (cnt_reg > CNT_5Q);
    // two-cell window [7T/4, 9T/4] and 1.5-cell window [5T/4, 7T/4]
    assign in_long  = (cnt_reg >= CNT_7Q) && (cnt_reg <= CNT_9Q);
    assign in_1p5   = (cnt_reg >= CNT_5Q) && (cnt_reg <= CNT_7Q);

    // even parity over a leading 1, the word and the parity cell itself;
    // the parity cell value is the direction of its mid-bit edge
    assign parity_ok = ~(^{1'b1, shift_reg, edge_rise});

    // Two-flop synchronizer plus one history flop for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_reg <= 3'b000;
        end else begin
            sync_reg <= {sync_reg[1:0], rx};
        end
    end

    // Frame decoder: cell timing, word assembly and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            start_cnt_reg <= 3'd0;
            bit_cnt_reg   <= 4'd0;
            shift_reg     <= 10'h000;
            fall_seen_reg <= 1'b0;
            active        <= 1'b0;
            data          <= 10'h000;
            data_valid    <= 1'b0;
            error         <= 1'b0;
            error_code    <= 2'd0;
        end else begin
            // strobes last one cycle; the counter free-runs up to 3T
            data_valid <= 1'b0;
            error      <= 1'b0;
            if (cnt_reg != CNT_MAX) begin
                cnt_reg <= cnt_reg + CW'(1);
            end

            case (state_reg)
                IDLE: begin
                    // first rising edge is taken as the mid-bit of start cell 1
                    if (edge_rise) begin
                        cnt_reg       <= '0;
                        start_cnt_reg <= 3'd1;
                        state_reg     <= START_BITS;
                    end
                end

                START_BITS: begin
                    if (past_mid) begin
                        // a long low after enough start cells opens the violation
                        if ((start_cnt_reg >= 3'd3) && !rx_s) begin
                            state_reg <= VIOLATION_LOW;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else if (edge_any && in_mid) begin
                        if (edge_rise) begin
                            cnt_reg <= '0;
                            if (start_cnt_reg != 3'd7) begin
                                start_cnt_reg <= start_cnt_reg + 3'd1;
                            end
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end

                VIOLATION_LOW: begin
                    if (edge_any) begin
                        if (edge_rise && in_long) begin
                            cnt_reg       <= '0;
                            fall_seen_reg <= 1'b0;
                            state_reg     <= VIOLATION_HIGH;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else if (cnt_reg > CNT_9Q) begin
                        state_reg <= IDLE;
                    end
                end

                VIOLATION_HIGH: begin
                    // high 1.5 cells, then the sync cell whose mid-bit
                    // rising edge lands two cells after the violation rise
                    if (edge_any) begin
                        if (!fall_seen_reg && edge_fall && in_1p5) begin
                            fall_seen_reg <= 1'b1;
                        end else if (fall_seen_reg && edge_rise && in_long) begin
                            cnt_reg     <= '0;
                            bit_cnt_reg <= 4'd9;
                            active      <= 1'b1;
                            state_reg   <= DATA_BIT;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else if (cnt_reg > CNT_9Q) begin
                        state_reg <= IDLE;
                    end
                end

                DATA_BIT: begin
                    if (past_mid) begin
                        error      <= 1'b1;
                        error_code <= ERR_NO_MID;
                        active     <= 1'b0;
                        cnt_reg    <= '0;
                        state_reg  <= LINE_QUIESCE;
                    end else if (edge_any && in_mid) begin
                        cnt_reg   <= '0;
                        shift_reg <= {shift_reg[8:0], edge_rise};
                        if (bit_cnt_reg == 4'd0) begin
                            state_reg <= PARITY_BIT;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg - 4'd1;
                        end
                    end
                end

                PARITY_BIT: begin
                    if (past_mid) begin
                        error      <= 1'b1;
                        error_code <= ERR_NO_MID;
                        active     <= 1'b0;
                        cnt_reg    <= '0;
                        state_reg  <= LINE_QUIESCE;
                    end else if (edge_any && in_mid) begin
                        cnt_reg <= '0;
                        // a rejected word leaves data untouched; the frame goes on
                        if (parity_ok) begin
                            data       <= shift_reg;
                            data_valid <= 1'b1;
                        end else begin
                            error      <= 1'b1;
                            error_code <= ERR_PARITY;
                        end
                        state_reg <= SYNC_BIT;
                    end
                end

                SYNC_BIT: begin
                    // '1' cell starts another word, '0' cell starts the end sequence
                    if (past_mid) begin
                        error      <= 1'b1;
                        error_code <= ERR_NO_MID;
                        active     <= 1'b0;
                        cnt_reg    <= '0;
                        state_reg  <= LINE_QUIESCE;
                    end else if (edge_any && in_mid) begin
                        cnt_reg <= '0;
                        if (edge_rise) begin
                            bit_cnt_reg <= 4'd9;
                            state_reg   <= DATA_BIT;
                        end else begin
                            state_reg <= END_SEQUENCE;
                        end
                    end
                end

                END_SEQUENCE: begin
                    // line must stay high until 5T/2 and drop before 3T
                    if (edge_fall) begin
                        active <= 1'b0;
                        if (cnt_reg >= CNT_5H) begin
                            state_reg <= IDLE;
                        end else begin
                            error      <= 1'b1;
                            error_code <= ERR_END;
                            cnt_reg    <= '0;
                            state_reg  <= LINE_QUIESCE;
                        end
                    end else if (cnt_reg == CNT_MAX) begin
                        error      <= 1'b1;
                        error_code <= ERR_END;
                        active     <= 1'b0;
                        cnt_reg    <= '0;
                        state_reg  <= LINE_QUIESCE;
                    end
                end

                LINE_QUIESCE: begin
                    // counter measures the current run of low samples
                    if (rx_s) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == CNT_2T_M1) begin
                        state_reg <= IDLE;
                    end
                end

                default: begin
                    active    <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coax_rx.sv
// Directed bench for coax_rx: a line driver builds frames cell by cell and a
// negedge monitor tallies strobes; every expectation is a hand-derived constant.
module tb_coax_rx;

    localparam int T = 8;

    logic       clk;
    logic       reset;
    logic       rx;
    logic       active;
    logic [9:0] data;
    logic       data_valid;
    logic       error;
    logic [1:0] error_code;

    int tests_run = 0;
    int tests_failed = 0;

    // monitor state
    int         dv_count = 0;
    int         err_count = 0;
    int         both_count = 0;
    int         dv_inactive = 0;
    int         active_rises = 0;
    logic       active_prev = 1'b0;
    logic [1:0] last_code = 2'd0;
    logic [9:0] data_at_err = 10'h000;
    logic [9:0] dv_q[$];

    coax_rx #(.CLOCKS_PER_BIT(T)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .active     (active),
        .data       (data),
        .data_valid (data_valid),
        .error      (error),
        .error_code (error_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog in case stimulus ever stalls
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Strobe monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (data_valid) begin
            dv_count++;
            dv_q.push_back(data);
            if (!active) dv_inactive++;
        end
        if (error) begin
            err_count++;
            last_code   = error_code;
            data_at_err = data;
        end
        if (data_valid && error) both_count++;
        if (active && !active_prev) active_rises++;
        active_prev = active;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %0h", tag, got);
        end
    endtask

    // drive a level for n clocks; calls start and end 1 time unit after posedge
    task automatic hold(input logic level, input int n);
        rx = level;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // bi-phase cell: '1' = low then high, '0' = high then low
    task automatic send_bit(input logic b);
        if (b) begin
            hold(1'b0, T / 2);
            hold(1'b1, T / 2);
        end else begin
            hold(1'b1, T / 2);
            hold(1'b0, T / 2);
        end
    endtask

    // start cells followed by the 1.5-cell low / 1.5-cell high violation
    task automatic send_preamble(input int nstart);
        for (int i = 0; i < nstart; i++) send_bit(1'b1);
        hold(1'b0, 3 * T / 2);
        hold(1'b1, 3 * T / 2);
    endtask

    // sync cell, ten data cells MSB first, even parity cell (optionally inverted)
    task automatic send_word(input logic [9:0] w, input logic flip);
        logic p;
        send_bit(1'b1);
        for (int i = 9; i >= 0; i--) send_bit(w[i]);
        p = ~(^w) ^ flip;
        send_bit(p);
    endtask

    // '0' cell then high for 2.25 cells, line left low
    task automatic send_end();
        send_bit(1'b0);
        hold(1'b1, 2 * T + T / 4);
        hold(1'b0, 4 * T);
    endtask

    task automatic send_frame(input logic [9:0] w);
        send_preamble(5);
        send_word(w, 1'b0);
        send_end();
    endtask

    int dv0, er0, ar0, qi;

    initial begin
        reset = 1'b0;
        rx    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_active", 32'(active), 32'h0);
        check("reset_data", 32'(data), 32'h000);
        check("reset_dv", 32'(data_valid), 32'h0);
        check("reset_err", 32'(error), 32'h0);
        check("reset_code", 32'(error_code), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        hold(1'b0, 2 * T);

        // single word loopback
        dv0 = dv_count; er0 = err_count; ar0 = active_rises; qi = dv_q.size();
        send_frame(10'h2A5);
        $display("[TB] frame 2A5 sent");
        check("w2a5_dv", 32'(dv_count - dv0), 32'd1);
        check("w2a5_data", 32'(data), 32'h2A5);
        check("w2a5_err", 32'(err_count - er0), 32'd0);
        check("w2a5_active_rises", 32'(active_rises - ar0), 32'd1);
        check("w2a5_active_at_dv", 32'(dv_inactive), 32'd0);
        check("w2a5_active_after", 32'(active), 32'h0);

        // back-to-back words in one frame
        dv0 = dv_count; er0 = err_count; ar0 = active_rises; qi = dv_q.size();
        send_preamble(5);
        send_word(10'h000, 1'b0);
        send_word(10'h3FF, 1'b0);
        send_end();
        $display("[TB] frame 000,3FF sent");
        check("b2b_dv", 32'(dv_count - dv0), 32'd2);
        if (dv_q.size() >= qi + 2) begin
            check("b2b_first", 32'(dv_q[qi]), 32'h000);
            check("b2b_second", 32'(dv_q[qi+1]), 32'h3FF);
        end else begin
            check("b2b_queue_depth", 32'(dv_q.size() - qi), 32'd2);
        end
        check("b2b_active_rises", 32'(active_rises - ar0), 32'd1);
        check("b2b_err", 32'(err_count - er0), 32'd0);

        // inverted parity on the first word, good second word
        dv0 = dv_count; er0 = err_count;
        send_preamble(5);
        send_word(10'h0F0, 1'b1);
        send_word(10'h123, 1'b0);
        send_end();
        $display("[TB] frame 0F0(bad parity),123 sent");
        check("par_err", 32'(err_count - er0), 32'd1);
        check("par_code", 32'(last_code), 32'd1);
        check("par_data_kept", 32'(data_at_err), 32'h3FF);
        check("par_dv", 32'(dv_count - dv0), 32'd1);
        check("par_next_data", 32'(data), 32'h123);

        // line stuck high after the 5th data cell
        dv0 = dv_count; er0 = err_count;
        send_preamble(5);
        send_bit(1'b1);
        for (int i = 9; i >= 5; i--) send_bit(1'b1 & ((10'h2A5 >> i) & 1'b1));
        hold(1'b1, 3 * T);
        $display("[TB] stuck-high frame sent");
        check("mid_err", 32'(err_count - er0), 32'd1);
        check("mid_code", 32'(last_code), 32'd2);
        check("mid_active", 32'(active), 32'h0);
        hold(1'b0, 3 * T);
        send_frame(10'h0CC);
        $display("[TB] frame 0CC sent");
        check("mid_recover_dv", 32'(dv_count - dv0), 32'd1);
        check("mid_recover_data", 32'(data), 32'h0CC);

        // end sequence dropping too early
        dv0 = dv_count; er0 = err_count;
        send_preamble(5);
        send_word(10'h1E1, 1'b0);
        send_bit(1'b0);
        hold(1'b1, T);
        hold(1'b0, 4 * T);
        $display("[TB] short end sequence sent");
        check("end_err", 32'(err_count - er0), 32'd1);
        check("end_code", 32'(last_code), 32'd3);
        check("end_dv", 32'(dv_count - dv0), 32'd1);
        check("end_data", 32'(data), 32'h1E1);

        // only two start cells
        er0 = err_count; ar0 = active_rises;
        send_preamble(2);
        hold(1'b0, 4 * T);
        $display("[TB] two-start preamble sent");
        check("start2_active", 32'(active_rises - ar0), 32'd0);
        check("start2_err", 32'(err_count - er0), 32'd0);

        // ten closely spaced edges
        er0 = err_count; ar0 = active_rises;
        for (int i = 0; i < 10; i++) hold((i % 2) == 0, 3);
        hold(1'b0, 4 * T);
        $display("[TB] fast edges sent");
        check("glitch_active", 32'(active_rises - ar0), 32'd0);
        check("glitch_err", 32'(err_count - er0), 32'd0);

        // reset during data cell 4 of 155, then a full 155 frame
        dv0 = dv_count; er0 = err_count;
        send_preamble(5);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        hold(1'b0, T / 2);
        hold(1'b1, T / 4);
        check("rst_no_dv_before", 32'(dv_count - dv0), 32'd0);
        check("rst_no_err_before", 32'(err_count - er0), 32'd0);
        check("rst_active_before", 32'(active), 32'h1);
        reset = 1'b0;
        hold(1'b0, 3);
        check("rst_active", 32'(active), 32'h0);
        check("rst_data", 32'(data), 32'h000);
        reset = 1'b1;
        hold(1'b0, 2 * T);
        send_frame(10'h155);
        $display("[TB] frame 155 after reset sent");
        check("rst_dv", 32'(dv_count - dv0), 32'd1);
        check("rst_data_after", 32'(data), 32'h155);
        check("rst_err", 32'(err_count - er0), 32'd0);

        check("dv_err_overlap", 32'(both_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
